butterfly_pipe: RTL and testbench
=================================

Name: butterfly_pipe

Overview:
Pipelined, parametrised radix-2 butterfly for the MDC FFT datapath; successor to the combinational compute/bypass butterfly.
- Adds a valid/ready handshake with backpressure, four operating modes (including swap and -j rotation for radix-2^2 stages), and optional per-sample scaling by 1/2 with rounding.
- Supports configurable output width with overflow detection and a sticky overflow flag.
- Sits between delay-commutator stages; one complex pair in, one complex pair out per accepted transfer.

Parameters:
- IN_W, 9: signed width of each input real/imag component.
- OUT_W, 10: signed width of each output component; the full-growth result is IN_W+1 bits, so OUT_W < IN_W+1 enables overflow handling.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept the input pair this cycle.
- mode  in  2  00 compute, 01 bypass, 10 swap, 11 compute with x1 rotated by -j; sampled with the data.
- scale  in  1  1 = divide the result by 2 with rounding; sampled with the data.
- x0_re, x0_im, x1_re, x1_im  in  IN_W each  signed input pair.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts the output pair.
- y0_re, y0_im, y1_re, y1_im  out  OUT_W each  signed output pair.
- ovf  out  1  sticky overflow flag.
- clr_ovf  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst=1): both stage valids 0, all data registers 0, ovf 0. Outputs read out_valid=0, y*=0, in_ready=1.
  - Reset mid-operation discards in-flight samples.
- Two register stages; latency 2 cycles from accepted input to out_valid with out_ready held high. Throughput 1 pair/cycle.
- Advance condition adv = out_ready | ~out_valid. in_ready = adv.
  - Input accepted when in_valid & in_ready.
  - On adv both stages shift together; a stage-1 bubble propagates as valid=0.
  - When adv=0, all registers hold; outputs stay stable while out_valid=1 and out_ready=0.
- Stage 1 (arithmetic, IN_W+1 bits, operands sign-extended):
  - 00: y0 = x0+x1, y1 = x0-x1.
  - 01: y0 = x0, y1 = x1.
  - 10: y0 = x1, y1 = x0.
  - 11: x1' = (x1_im, -x1_re); y0 = x0+x1', y1 = x0-x1'. The negation is done at IN_W+1 bits, so -(-2^(IN_W-1)) is exact.
  - scale is registered alongside the results.
- Stage 2 (per component v, IN_W+1 bits):
  - scale=1: r = (v+1) >>> 1, computed at IN_W+2 bits (round half toward +inf). scale=0: r = v.
  - If r fits in OUT_W, output r (sign-extended if OUT_W > IN_W+1).
  - Else out-of-range handling per the optional feature below.
- ovf:
  - Set when any of the 4 components of a valid stage-2 result is out of range, evaluated on the cycle the result enters stage 2.
  - clr_ovf clears it; set wins on a simultaneous set and clear.
- Scaling and the out-of-range check apply in all modes, including bypass and swap.

Optional Feature:
- BFLY_SAT_EN defined: out-of-range components clamp to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
- Not defined: out-of-range components wrap (low OUT_W bits kept).
- ovf behaviour is identical in both builds.

Test Plan:
- Compute, mode=00, scale=0: x0=(100,-50), x1=(27,20) -> 2 cycles later out_valid=1, y0=(127,-30), y1=(73,-70), ovf=0.
- Mode 11: x0=(10,0), x1=(0,5) -> y0=(15,0), y1=(5,0). Mode 10 with the same inputs -> y0=(0,5), y1=(10,0).
- Scale rounding: x0_re=2, x1_re=1, mode=00, scale=1 -> y0_re=2, y1_re=1. x0_re=-2, x1_re=-1 -> y0_re=-1, y1_re=0.
- OUT_W=9: x0_re=x1_re=255 (sum 510) -> BFLY_SAT_EN build y0_re=255; wrap build y0_re=-2. ovf=1 and stays 1 until clr_ovf. clr_ovf pulsed together with a new overflow -> ovf stays 1.
- Backpressure: stream 4 pairs with out_ready=0 for 3 cycles -> in_ready drops once both stages are full, y* held stable, all 4 pairs emerge in order with none lost or duplicated.
- Assert rst with both stages valid -> out_valid=0 and y*=0 immediately; after release the first new input appears 2 cycles later.

Source files
------------

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: two-stage radix-2 butterfly with valid/ready, modes, 1/2 scaling and sticky overflow.
// Define BFLY_SAT_EN to saturate out-of-range outputs instead of wrapping.
module butterfly_pipe #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              mode,
  input  logic                    scale,
  input  logic signed [IN_W-1:0]  x0_re,
  input  logic signed [IN_W-1:0]  x0_im,
  input  logic signed [IN_W-1:0]  x1_re,
  input  logic signed [IN_W-1:0]  x1_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y0_re,
  output logic signed [OUT_W-1:0] y0_im,
  output logic signed [OUT_W-1:0] y1_re,
  output logic signed [OUT_W-1:0] y1_im,
  output logic                    ovf,
  input  logic                    clr_ovf
);
  localparam int GW = IN_W + 1;
  localparam int RW = GW + 1;
  localparam int HB = (OUT_W > GW) ? GW : OUT_W - 1;
`ifdef BFLY_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic                    w_adv, w_set;
  logic signed [GW-1:0]    w_x0r, w_x0i, w_x1r, w_x1i, w_br, w_bi;
  logic signed [GW-1:0]    w_a [4];
  logic signed [OUT_W-1:0] w_y [4];
  logic [3:0]              w_of;
  logic                    r_v1, r_s1, r_v2, r_ovf;
  logic signed [GW-1:0]    r_a [4];
  logic signed [OUT_W-1:0] r_y [4];

  // Returns {out_of_range, result}; range check looks at the bits above the OUT_W sign bit.
  function automatic logic [OUT_W:0] conv(input logic signed [GW-1:0] v, input logic s);
    logic signed [RW-1:0] t;
    logic [GW-HB:0]       hi;
    logic                 fit;
    logic [OUT_W-1:0]     y;
    t = RW'(v);
    if (s) t = (t + RW'(1)) >>> 1;
    hi = t[GW:HB];
    fit = &hi | ~|hi;
    y = (fit || !SAT) ? OUT_W'(t) : t[GW] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return {~fit, y};
  endfunction

  assign w_adv     = out_ready | ~r_v2;
  assign in_ready  = w_adv;
  assign out_valid = r_v2;
  assign ovf       = r_ovf;
  assign {y0_re, y0_im, y1_re, y1_im} = {r_y[0], r_y[1], r_y[2], r_y[3]};

  // Mode 11 rotates x1 by -j: (re, im) -> (im, -re), negated at full growth width.
  assign w_x0r = GW'(x0_re);
  assign w_x0i = GW'(x0_im);
  assign w_x1r = GW'(x1_re);
  assign w_x1i = GW'(x1_im);
  assign w_br  = (mode == 2'b11) ? w_x1i : w_x1r;
  assign w_bi  = (mode == 2'b11) ? -w_x1r : w_x1i;
  assign w_a[0] = (mode == 2'b01) ? w_x0r : (mode == 2'b10) ? w_x1r : w_x0r + w_br;
  assign w_a[1] = (mode == 2'b01) ? w_x0i : (mode == 2'b10) ? w_x1i : w_x0i + w_bi;
  assign w_a[2] = (mode == 2'b01) ? w_x1r : (mode == 2'b10) ? w_x0r : w_x0r - w_br;
  assign w_a[3] = (mode == 2'b01) ? w_x1i : (mode == 2'b10) ? w_x0i : w_x0i - w_bi;

  always_comb begin
    w_of = '0;
    for (int i = 0; i < 4; i++) {w_of[i], w_y[i]} = conv(r_a[i], r_s1);
  end

  assign w_set = w_adv & r_v1 & |w_of;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_s1  <= 1'b0;
      r_v2  <= 1'b0;
      r_ovf <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_a[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      if (w_adv) begin
        r_v1 <= in_valid;
        r_s1 <= scale;
        r_v2 <= r_v1;
        for (int i = 0; i < 4; i++) begin
          r_a[i] <= w_a[i];
          r_y[i] <= w_y[i];
        end
      end
      r_ovf <= w_set | (r_ovf & ~clr_ovf);
    end
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: scoreboard bench for butterfly_pipe (IN_W=9, OUT_W=9) with a arithmetic reference model.
module tb_butterfly_pipe;
  localparam int IW = 9;
  localparam int OW = 9;

  logic clk = 0, rst = 1, in_valid = 0, in_ready, scale = 0;
  logic out_valid, out_ready = 1, ovf, clr_ovf = 0;
  logic [1:0] mode = 0;
  logic signed [IW-1:0] x0_re = 0, x0_im = 0, x1_re = 0, x1_im = 0;
  logic signed [OW-1:0] y0_re, y0_im, y1_re, y1_im;

  typedef struct {int a; int b; int c; int d; bit of;} exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, failures = 0;
  bit m_ovf = 0, done = 0;

  butterfly_pipe #(.IN_W(IW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .scale(scale),
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int fit(input int v, input bit s, output bit of);
    int lo = -(1 << (OW - 1));
    int hi = (1 << (OW - 1)) - 1;
    int r = s ? (v + 1) >>> 1 : v;
    of = (r < lo) || (r > hi);
`ifdef BFLY_SAT_EN
    if (of) r = (r < lo) ? lo : hi;
`else
    if (of) begin
      r = r & ((1 << OW) - 1);
      if (r > hi) r -= (1 << OW);
    end
`endif
    return r;
  endfunction

  function automatic exp_t model(input int m, input bit s, input int a, input int b, input int c, input int d);
    int p[4];
    bit o;
    exp_t e;
    case (m)
      0: p = '{a + c, b + d, a - c, b - d};
      1: p = '{a, b, c, d};
      2: p = '{c, d, a, b};
      default: p = '{a + d, b - c, a - d, b + c};
    endcase
    e.of = 0;
    e.a = fit(p[0], s, o); e.of |= o;
    e.b = fit(p[1], s, o); e.of |= o;
    e.c = fit(p[2], s, o); e.of |= o;
    e.d = fit(p[3], s, o); e.of |= o;
    return e;
  endfunction

  task automatic send(input int m, input int s, input int a, input int b, input int c, input int d);
    int n = 0;
    bit acc = 0;
    logic [31:0] va = a, vb = b, vc = c, vd = d, vm = m;
    mode = vm[1:0]; scale = s[0];
    x0_re = va[IW-1:0]; x0_im = vb[IW-1:0]; x1_re = vc[IW-1:0]; x1_im = vd[IW-1:0];
    in_valid = 1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    if (acc) q.push_back(model(m, s[0], a, b, c, d));
    else chk("accept_timeout", 0, 1);
    #1 in_valid = 0;
  endtask

  function automatic int rnd();
    int r = $urandom_range(0, 7);
    return (r == 0) ? 255 : (r == 1) ? -256 : int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic send_rand();
    send($urandom_range(0, 3), $urandom_range(0, 1), rnd(), rnd(), rnd(), rnd());
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ovf();
    clr_ovf = 1;
    @(posedge clk);
    #1 clr_ovf = 0;
    m_ovf = 0;
    chk("ovf_cleared", ovf, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        me = q[0];
        chk("y0_re", y0_re, me.a);
        chk("y0_im", y0_im, me.b);
        chk("y1_re", y1_re, me.c);
        chk("y1_im", y1_im, me.d);
        if (out_ready) begin
          void'(q.pop_front());
          m_ovf |= me.of;
          chk("ovf", ovf, m_ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y0_re", y0_re, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf", ovf, 0);
    rst = 0;
    send(0, 0, 100, -50, 27, 20);
    chk("lat_valid_c1", out_valid, 0);
    @(posedge clk);
    #1 chk("lat_valid_c2", out_valid, 1);
    send(3, 0, 10, 0, 0, 5);
    send(2, 0, 10, 0, 0, 5);
    send(0, 1, 2, 0, 1, 0);
    send(0, 1, -2, 0, -1, 0);
    send(1, 1, -256, 255, 7, -7);
    drain();
    chk("ovf_none", ovf, 0);
    send(0, 0, 255, 0, 255, 0);
    drain();
    chk("ovf_sticky", ovf, 1);
    clear_ovf();
    send(0, 0, 255, 0, 255, 0);
    clr_ovf = 1;
    @(posedge clk);
    #1 clr_ovf = 0;
    chk("ovf_set_wins", ovf, 1);
    drain();
    clear_ovf();
    out_ready = 0;
    fork
      for (int i = 0; i < 4; i++) send_rand();
      begin
        repeat (3) @(posedge clk);
        #1 chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1;
      end
    join
    drain();
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    drain();
    out_ready = 0;
    send(0, 0, 255, 255, 255, 255);
    send(0, 0, 3, 4, 5, 6);
    #2 rst = 1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_y0_re", y0_re, 0);
    chk("mid_rst_y1_im", y1_im, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_ovf", ovf, 0);
    q.delete();
    m_ovf = 0;
    @(posedge clk);
    #1 rst = 0;
    out_ready = 1;
    send(0, 0, 1, 2, 3, 4);
    chk("post_rst_c1", out_valid, 0);
    @(posedge clk);
    #1 chk("post_rst_c2", out_valid, 1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
